// File: rtl/simon_key_sched_param.sv
// Parametrised Simon key-schedule engine: streams T round keys over valid/ready
// and keeps the complete schedule in an internal table with a combinational read port.
module simon_key_sched_param #(
  parameter int N    = 16,
  parameter int M    = 4,
  parameter int T    = 32,
  parameter int ZSEL = 0,
  parameter int AW   = $clog2(T)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M*N-1:0] key_in,
  output logic           busy,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [AW-1:0]  rk_index,
  output logic [N-1:0]   rk_data,
  output logic           done,
  output logic           table_valid,
  input  logic [AW-1:0]  rd_addr,
  output logic [N-1:0]   rd_data
);

  generate
    if (!((N == 16 || N == 24 || N == 32 || N == 48 || N == 64) &&
          (M >= 2) && (M <= 4) && (T >= M + 1) && (T <= 72) &&
          (ZSEL >= 0) && (ZSEL <= 4) && (AW == $clog2(T)))) begin : g_bad_param
      $fatal(1, "simon_key_sched_param: illegal parameter combination");
    end
  endgenerate

  // Literals are written in published order, so sequence bit k sits at vector bit 61-k.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] Z_SEQ = (ZSEL == 0) ? Z0 :
                                  (ZSEL == 1) ? Z1 :
                                  (ZSEL == 2) ? Z2 :
                                  (ZSEL == 3) ? Z3 : Z4;
  localparam int IW = $clog2(T + M);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state;
  logic [N-1:0]   win [M];
  logic [N-1:0]   table_mem [T];
  logic [5:0]     zi;
  logic [N-1:0]   gen_tmp;
  logic [N-1:0]   new_word;
  logic [IW-1:0]  wr_idx;
  logic           accept;
  logic           gen_en;
  logic           last;
  logic           z_bit;

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int s);
    return (x >> s) | (x << (N - s));
  endfunction

  assign accept  = (state == RUN) && rk_ready;
  assign last    = (rk_index == AW'(T - 1));
  // Word i = j+M is produced when key j is accepted, while it still lies inside the schedule.
  assign wr_idx  = IW'(rk_index) + IW'(M);
  assign gen_en  = accept && (wr_idx < IW'(T));
  assign z_bit   = Z_SEQ[6'd61 - zi];
  assign rk_data = win[0];
  assign rd_data = table_mem[rd_addr];

  // Window holds k[i-M] .. k[i-1] for the word about to be generated.
  always_comb begin
    gen_tmp = ror(win[M-1], 3);
    if (M == 4) gen_tmp = gen_tmp ^ win[1];
    gen_tmp  = gen_tmp ^ ror(gen_tmp, 1);
    new_word = ~N'(3) ^ {{(N-1){1'b0}}, z_bit} ^ win[0] ^ gen_tmp;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      rk_valid    <= 1'b0;
      done        <= 1'b0;
      table_valid <= 1'b0;
      rk_index    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            rk_valid    <= 1'b1;
            rk_index    <= '0;
            table_valid <= 1'b0;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (last) begin
              state       <= FIN;
              rk_valid    <= 1'b0;
              done        <= 1'b1;
              table_valid <= 1'b1;
            end else begin
              rk_index <= rk_index + AW'(1);
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: window and table carry no reset; a reset edge still suppresses any update.
  always_ff @(posedge clk) begin
    if (rst && (state == IDLE) && start) begin
      for (int i = 0; i < M; i++) begin
        win[i]       <= key_in[i*N +: N];
        table_mem[i] <= key_in[i*N +: N];
      end
      zi <= 6'd0;
    end else if (rst && accept) begin
      for (int i = 0; i < M - 1; i++) win[i] <= win[i+1];
      win[M-1] <= new_word;
      if (gen_en) table_mem[AW'(wr_idx)] <= new_word;
      zi <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
    end
  end

endmodule

// File: tb/tb_simon_key_sched_param.sv
// Directed bench for the Simon key-schedule engine across four parameter sets,
// checked against an independent string-driven schedule model and a Simon128/256 encryption.
module tb_simon_key_sched_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, rk_ready;
  logic [6:0] rd_addr;
  int         sel;

  localparam logic [63:0]  KEY_A = 64'h1918_1110_0908_0100;
  localparam logic [255:0] KEY_B = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [71:0]  KEY_C = 72'h121110_0a0908_020100;
  localparam logic [63:0]  KEY_D = 64'h13121110_0b0a0908;

  logic busy_a, val_a, done_a, tv_a; logic [4:0] idx_a; logic [15:0] dat_a, rdd_a;
  logic busy_b, val_b, done_b, tv_b; logic [6:0] idx_b; logic [63:0] dat_b, rdd_b;
  logic busy_c, val_c, done_c, tv_c; logic [5:0] idx_c; logic [23:0] dat_c, rdd_c;
  logic busy_d, val_d, done_d, tv_d; logic [5:0] idx_d; logic [31:0] dat_d, rdd_d;
  logic st_a, st_b, st_c, st_d;

  assign st_a = start && (sel == 0);
  assign st_b = start && (sel == 1);
  assign st_c = start && (sel == 2);
  assign st_d = start && (sel == 3);

  simon_key_sched_param #(.N(16), .M(4), .T(32), .ZSEL(0)) dut_a (
    .clk(clk), .rst(rst), .start(st_a), .key_in(KEY_A), .busy(busy_a), .rk_valid(val_a),
    .rk_ready(rk_ready), .rk_index(idx_a), .rk_data(dat_a), .done(done_a),
    .table_valid(tv_a), .rd_addr(rd_addr[4:0]), .rd_data(rdd_a));

  simon_key_sched_param #(.N(64), .M(4), .T(72), .ZSEL(4)) dut_b (
    .clk(clk), .rst(rst), .start(st_b), .key_in(KEY_B), .busy(busy_b), .rk_valid(val_b),
    .rk_ready(rk_ready), .rk_index(idx_b), .rk_data(dat_b), .done(done_b),
    .table_valid(tv_b), .rd_addr(rd_addr), .rd_data(rdd_b));

  simon_key_sched_param #(.N(24), .M(3), .T(36), .ZSEL(0)) dut_c (
    .clk(clk), .rst(rst), .start(st_c), .key_in(KEY_C), .busy(busy_c), .rk_valid(val_c),
    .rk_ready(rk_ready), .rk_index(idx_c), .rk_data(dat_c), .done(done_c),
    .table_valid(tv_c), .rd_addr(rd_addr[5:0]), .rd_data(rdd_c));

  simon_key_sched_param #(.N(32), .M(2), .T(42), .ZSEL(2)) dut_d (
    .clk(clk), .rst(rst), .start(st_d), .key_in(KEY_D), .busy(busy_d), .rk_valid(val_d),
    .rk_ready(rk_ready), .rk_index(idx_d), .rk_data(dat_d), .done(done_d),
    .table_valid(tv_d), .rd_addr(rd_addr[5:0]), .rd_data(rdd_d));

  logic c_busy, c_valid, c_done, c_tv;
  int          c_idx;
  logic [63:0] c_data, c_rd;

  always_comb begin
    c_busy = 1'b0; c_valid = 1'b0; c_done = 1'b0; c_tv = 1'b0;
    c_idx = 0; c_data = '0; c_rd = '0;
    case (sel)
      0: begin c_busy = busy_a; c_valid = val_a; c_done = done_a; c_tv = tv_a;
               c_idx = int'(idx_a); c_data = 64'(dat_a); c_rd = 64'(rdd_a); end
      1: begin c_busy = busy_b; c_valid = val_b; c_done = done_b; c_tv = tv_b;
               c_idx = int'(idx_b); c_data = dat_b; c_rd = rdd_b; end
      2: begin c_busy = busy_c; c_valid = val_c; c_done = done_c; c_tv = tv_c;
               c_idx = int'(idx_c); c_data = 64'(dat_c); c_rd = 64'(rdd_c); end
      default: begin c_busy = busy_d; c_valid = val_d; c_done = done_d; c_tv = tv_d;
               c_idx = int'(idx_d); c_data = 64'(dat_d); c_rd = 64'(rdd_d); end
    endcase
  end

  int          passed = 0;
  int          total = 0;
  logic [63:0] gold [72];
  logic [15:0] spec6 [6];
  string       zs [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int s, input int n);
    logic [63:0] mask;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((x >> s) | (x << (n - s))) & mask;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] x, input int s);
    return (x << s) | (x >> (64 - s));
  endfunction

  task automatic gen_gold(input int n, input int m, input int t, input int zsel, input logic [255:0] key);
    logic [63:0] mask, tmp, zb;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < m; i++) gold[i] = 64'(key >> (i * n)) & mask;
    for (int i = m; i < t; i++) begin
      tmp = rotr(gold[i-1], 3, n);
      if (m == 4) tmp = tmp ^ gold[i-3];
      tmp = tmp ^ rotr(tmp, 1, n);
      zb = (zs[zsel][(i - m) % 62] == "1") ? 64'd1 : 64'd0;
      gold[i] = (mask & ~64'd3) ^ zb ^ gold[i-m] ^ tmp;
    end
  endtask

  task automatic chk_table(input int t, input string tag);
    for (int i = 0; i < t; i++) begin
      rd_addr = 7'(i);
      #1;
      chk(tag, c_rd, gold[i]);
    end
    step();
  endtask

  // One expansion from IDLE; optional stall, start re-pulse and mid-run reset at given key indices.
  task automatic do_run(input int t, input int stall_idx, input int stall_n,
                        input int pulse_idx, input int abort_idx, input bit spec_chk);
    int cyc, nvalid, exp_idx, hold, stalled;
    bit fin;
    cyc = 0; nvalid = 0; exp_idx = 0; hold = 0; stalled = 0; fin = 1'b0;
    start = 1'b1; rk_ready = 1'b1;
    step();
    start = 1'b0; cyc = 1;
    while (!fin && cyc < 400) begin
      if (c_valid) begin
        nvalid++;
        if (exp_idx >= t) begin
          chk("overrun_index", 64'(exp_idx), 64'(t - 1));
          fin = 1'b1;
        end else begin
          chk("rk_index", 64'(c_idx), 64'(exp_idx));
          chk("rk_data", c_data, gold[exp_idx]);
          if (spec_chk && exp_idx < 6) chk("spec_key", c_data, 64'(spec6[exp_idx]));
          if (exp_idx == abort_idx) begin
            rst = 1'b0; start = 1'b1;
            step();
            rst = 1'b1; start = 1'b0;
            chk("abort_busy", 64'(c_busy), 0);
            chk("abort_rk_valid", 64'(c_valid), 0);
            chk("abort_table_valid", 64'(c_tv), 0);
            chk("abort_done", 64'(c_done), 0);
            chk("abort_rk_index", 64'(c_idx), 0);
            for (int k = 0; k < 3; k++) begin
              step();
              chk("abort_no_done", 64'(c_done | c_valid), 0);
            end
            return;
          end
          rk_ready = 1'b1; start = 1'b0;
          if (exp_idx == stall_idx) begin
            hold++;
            if (stalled < stall_n) begin rk_ready = 1'b0; stalled++; end
          end
          if (exp_idx == pulse_idx) start = 1'b1;
          if (rk_ready) exp_idx++;
        end
      end else if (c_done) begin
        fin = 1'b1;
      end
      if (!fin) begin step(); cyc++; end
    end
    chk("done_seen", 64'(fin), 1);
    chk("done_cycle", 64'(cyc), 64'(t + 1 + stall_n));
    chk("valid_cycles", 64'(nvalid), 64'(t + stall_n));
    if (stall_n > 0) chk("hold_cycles", 64'(hold), 64'(stall_n + 1));
    chk("table_valid_fin", 64'(c_tv), 1);
    start = 1'b0; rk_ready = 1'b1;
    step();
    chk("done_pulse_end", 64'(c_done), 0);
    chk("busy_end", 64'(c_busy), 0);
    chk("rk_valid_end", 64'(c_valid), 0);
    chk("table_valid_kept", 64'(c_tv), 1);
  endtask

  initial begin
    logic [63:0] x, y, tmp;
    zs[0] = "11111010001001010110000111001101111101000100101011000011100110";
    zs[1] = "10001110111110010011000010110101000111011111001001100001011010";
    zs[2] = "10101111011100000011010010011000101000010001111110010110110011";
    zs[3] = "11011011101011000110010111100000010010001010011100110100001111";
    zs[4] = "11010001111001101011011000100000010111000011001010010011101111";
    spec6[0] = 16'h0100; spec6[1] = 16'h0908; spec6[2] = 16'h1110;
    spec6[3] = 16'h1918; spec6[4] = 16'h71C3; spec6[5] = 16'hB649;

    rst = 1'b0; start = 1'b0; rk_ready = 1'b1; rd_addr = '0; sel = 0;
    step();
    step();
    chk("reset_busy", 64'(c_busy), 0);
    chk("reset_rk_valid", 64'(c_valid), 0);
    chk("reset_done", 64'(c_done), 0);
    chk("reset_table_valid", 64'(c_tv), 0);
    chk("reset_rk_index", 64'(c_idx), 0);
    rst = 1'b1;
    step();

    // Simon32/64: plain run, stalled run with start re-pulse, aborted run, fresh run.
    gen_gold(16, 4, 32, 0, 256'(KEY_A));
    do_run(32, -1, 0, -1, -1, 1'b1);
    rd_addr = 7'd4;
    #1;
    chk("rd_addr4", c_rd, 64'h71C3);
    chk_table(32, "table_a_run1");
    do_run(32, 5, 3, 10, -1, 1'b1);
    chk_table(32, "table_a_run2");
    do_run(32, -1, 0, -1, 12, 1'b1);
    do_run(32, -1, 0, -1, -1, 1'b1);

    // Simon128/256 with z wrap, then encrypt the published plaintext from the table.
    sel = 1;
    gen_gold(64, 4, 72, 4, KEY_B);
    do_run(72, -1, 0, -1, -1, 1'b0);
    chk_table(72, "table_b");
    x = 64'h74206e69206d6f6f;
    y = 64'h6d69732061207369;
    for (int i = 0; i < 72; i++) begin
      rd_addr = 7'(i);
      #1;
      tmp = x;
      x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ c_rd;
      y = tmp;
    end
    chk("ciphertext_x", x, 64'h8d2b5579afc8a3a0);
    chk("ciphertext_y", y, 64'h3bf72a87efe7b868);
    step();

    // Back-to-back runs: the second start lands in the cycle after done.
    sel = 2;
    gen_gold(24, 3, 36, 0, 256'(KEY_C));
    do_run(36, -1, 0, -1, -1, 1'b0);
    do_run(36, -1, 0, -1, -1, 1'b0);
    chk_table(36, "table_c");

    sel = 3;
    gen_gold(32, 2, 42, 2, 256'(KEY_D));
    do_run(42, -1, 0, -1, -1, 1'b0);
    do_run(42, 7, 2, -1, -1, 1'b0);
    chk_table(42, "table_d");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simon_key_sched_param.md
Name: simon_key_sched_param

Overview:
- Parametrised Simon key-schedule engine, the successor to the fixed 32/64 expander.
- Covers word size N, key words M, round count T and z-sequence ZSEL, i.e. every Simon variant from 32/64 to 128/256.
- Streams round keys one per cycle over a valid/ready port and keeps all T keys in an internal table with a random-access read port.
- Sits between the key-load logic and the round pipeline of the Simon datapath.

Parameters:
- N, 16: word width in bits. Legal values 16, 24, 32, 48, 64.
- M, 4: number of key words. Legal values 2, 3, 4.
- T, 32: number of round keys to generate. Legal range M+1 to 72.
- ZSEL, 0: constant-sequence select. Legal range 0 to 4 (z0 to z4).
- AW, $clog2(T): width of the round-key index and address.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-low reset.
- start, input, 1: request a new expansion. Accepted only in IDLE.
- key_in, input, M*N: master key, where k[i] = key_in[i*N +: N] (k0 is the least-significant word).
- busy, output, 1: high from the cycle after start is accepted until done.
- rk_valid, output, 1: a round key is presented.
- rk_ready, input, 1: the consumer accepts the presented key.
- rk_index, output, AW: index j of the presented key.
- rk_data, output, N: round key k[j].
- done, output, 1: one-cycle pulse after the last key is accepted.
- table_valid, output, 1: the internal table holds a complete schedule.
- rd_addr, input, AW: table read address.
- rd_data, output, N: combinational read of table[rd_addr]. Undefined when rd_addr >= T.

Behaviour:
- Reset (clk edge with rst=0):
  - State goes to IDLE.
  - busy, rk_valid, done and table_valid go to 0; rk_index goes to 0.
  - Table contents are not cleared.
  - Reset in mid-run aborts the run at that edge, with no done pulse.
- State machine: IDLE -> RUN -> FIN -> IDLE.
  - IDLE: on start=1, load the shift window W[0..M-1] = k0..k(M-1), write k0..k(M-1) to the table, set j=0, clear table_valid, go to RUN.
  - RUN: rk_valid=1, rk_index=j, rk_data=k[j].
    - If rk_ready=1: advance j. If j=T-1, go to FIN.
    - If rk_ready=0: rk_index and rk_data hold stable and no other state changes.
  - FIN: lasts one cycle. done=1, table_valid=1, busy=0 next, then IDLE.
- start is ignored in RUN and FIN. It is also ignored on the reset edge.
- First key appears the cycle after start is accepted. With rk_ready tied high, the T keys occupy T consecutive cycles and done follows on the next cycle.
- Generation for i >= M, one new word per accepted key while i < T:
  - tmp = ROR(k[i-1], 3). If M=4, tmp ^= k[i-3].
  - tmp ^= ROR(tmp, 1).
  - k[i] = c ^ z ^ k[i-M] ^ tmp, where:
    - c = 2^N - 4 (all ones except the two LSBs);
    - z = bit ((i-M) mod 62) of z_ZSEL, with bit 0 the leftmost character of the published strings below.
- All rotations are within N bits. All arithmetic is bitwise; there is no carry.
- Each new k[i] is written to table[i] in the same cycle it enters the window.
- The window shifts W[0..M-2] <= W[1..M-1] and W[M-1] <= k[i]. There is no shift when stalled.
- The z index wraps modulo 62 for T > 62 (128-bit keys use up to 72 rounds).
- z sequences (62 bits each, bit 0 first):
  - z0 = 11111010001001010110000111001101111101000100101011000011100110
  - z1 = 10001110111110010011000010110101000111011111001001100001011010
  - z2 = 10101111011100000011010010011000101000010001111110010110110011
  - z3 = 11011011101011000110010111100000010010001010011100110100001111
  - z4 = 11010001111001101011011000100000010111000011001010010011101111
- rd_data may be read at any time. Contents are guaranteed only while table_valid=1.
- An accepted start clears table_valid on the same edge.
- Illegal parameter values must fail elaboration.

Test Plan:
- N=16, M=4, ZSEL=0, T=32, key_in=64'h1918_1110_0908_0100, rk_ready=1 -> rk_data 0x0100, 0x0908, 0x1110, 0x1918, 0x71C3, 0xB649 on cycles 1-6 after start; 32 valid cycles; done on cycle 33; table_valid=1; rd_addr=4 gives 0x71C3.
- Same run with rk_ready low for 3 cycles while index 5 is presented -> rk_index=5 and rk_data=0xB649 held for 4 cycles; total 35 valid cycles; table contents identical to the previous run.
- Pulse start again during RUN at index 10 -> ignored; sequence and done timing unchanged.
- Drive rst=0 at index 12 -> next cycle busy=0, rk_valid=0, table_valid=0, no done. A new start then produces the full sequence from index 0.
- N=64, M=4, ZSEL=4, T=72 with the published Simon128/256 key -> k[4..71] match the golden model, including z wrap at i=66. Encrypting with the table yields the published ciphertext.
- N=24, M=3, ZSEL=0, T=36 and N=32, M=2, ZSEL=2, T=42 -> all keys match the golden model. Back-to-back start in the cycle after done is accepted.
